memfifo_write_arbiter: RTL
==========================

// Module: memfifo_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the DRAM FIFO write port (128-bit words, full flag) among NUM_REQ producers.
//  Producers include the USB OUT packer and DAC/ADC capture paths. Each producer streams 128-bit words on
//  valid/ready and ends a burst with a last flag. Grants are burst-locked so one producer's words stay contiguous.
//  Sits between the producers and dram_fifo's write side, in the ifclk domain.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  MAX_BURST  64   max words per grant before forced re-arbitration (power of 2, 2..256)
//  CNT_W      32   width of per-requester statistics counters (only with FIFO_ARB_STATS_EN)
// PORTS
//  ifclk          in   1            clock; all logic rising-edge
//  reset          in   1            asynchronous, active-high
//  flush          in   1            sync: drop pending word, abort burst, return to ARB
//  req_data       in   NUM_REQ*128  word of requester i at [i*128 +: 128]
//  req_valid      in   NUM_REQ      requester i has a word
//  req_last       in   NUM_REQ      word on req_data is last of burst (sampled with valid)
//  req_ready      out  NUM_REQ      word accepted when valid&ready
//  grant          out  NUM_REQ      one-hot current owner (0 in ARB)
//  fifo_data_in   out  128          word to FIFO
//  fifo_wr_en     out  1            write strobe
//  fifo_wr_full   in   1            FIFO full
//  fifo_wr_err    in   1            FIFO write error
//  wr_err_sticky  out  1            latched fifo_wr_err, cleared by reset/flush
//  busy           out  1            state==BURST or output word pending
//  stat_words     out  NUM_REQ*CNT_W  words accepted per requester (FIFO_ARB_STATS_EN only)
// BEHAVIOUR
//  Reset: state=ARB, rr_ptr=0, out_valid=0, fifo_data_in=0, grant=0, req_ready=0, wr_err_sticky=0, stats=0.
//  Output stage: one register (out_valid, fifo_data_in).
//   - fifo_wr_en = out_valid & ~fifo_wr_full (combinational).
//   - The word holds while full; nothing is ever written while full.
//  States:
//   - ARB: pick the first i with req_valid[i], scanning from rr_ptr upward with wrap.
//     On a hit: grant<=onehot(i), beat_cnt<=0, ->BURST. Otherwise stay. ARB costs exactly one bubble cycle.
//   - BURST: req_ready[g] = ~out_valid | ~fifo_wr_full. All other req_ready are 0.
//     On accept: load out register, beat_cnt++.
//     Leave to ARB (grant<=0, rr_ptr<=g+1 mod NUM_REQ) when the accepted word has req_last
//     or beat_cnt reaches MAX_BURST-1.
//     Valid low in BURST: hold the grant and wait (no timeout).
//  Throughput: 1 word/cycle sustained within a burst while not full; accept-to-fifo_wr_en latency 1 cycle.
//  Simultaneous accept and write in the same cycle: the register refills; no bubble.
//  Full: req_ready drops the same cycle if out_valid. No data loss, no duplicates.
//  flush (priority over all except reset): out_valid<=0, grant<=0, ->ARB, wr_err_sticky<=0.
//   rr_ptr is kept. The pending word is discarded.
//  reset mid-burst: immediate async clear; the in-flight word is lost (upstream is also reset).
//  beat_cnt width clog2(MAX_BURST); it never wraps, because the burst ends at MAX_BURST-1.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: per-requester CNT_W counters increment on each accepted word.
//   Counters saturate at all-ones and are cleared by reset only.
//  Undefined: stat_words is tied to 0 and no counter logic is built.
// STRUCTURE
//  Package memfifo_pkg: FIFO_WORD_W=128, arb state encoding (ARB=1'b0, BURST=1'b1), onehot helper function.
//  Sub-module rr_pick: combinational NUM_REQ round-robin picker (req vector, ptr -> onehot, index, hit).
//  Top holds the FSM, the output register, the error latch and the stats counters.
// TESTING
//  Req0 only, 3-word burst, last on word 3, full=0 -> fifo_wr_en high 3 consecutive cycles, data in order, 1 bubble, grant=0.
//  Req0..3 all valid continuously, last every word -> grants cycle 0,1,2,3,0; each word followed by one ARB bubble.
//  Req1 streams 100 words, no last, MAX_BURST=64 -> 64 words, re-arbitration, then the remaining 36 via a new grant.
//  Full asserted for 5 cycles mid-burst with out_valid=1 -> fifo_wr_en=0 and req_ready=0 for 5 cycles; words resume with no loss or duplicate.
//  flush while out_valid=1, full=1 -> next cycle out_valid=0, grant=0, state=ARB; pending word is never written.
//  Reset pulse mid-burst (async, between edges) -> all outputs 0 immediately; with STATS_EN, req2 accepting 10 words -> stat_words[2]=10.

Source files
------------

// File: rtl/memfifo_pkg.sv
// Shared types for the DRAM FIFO write-side arbiter: word width, arbiter state
// encoding and a one-hot helper.
package memfifo_pkg;

  localparam int FIFO_WORD_W = 128;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Wide enough for the largest supported requester count (8).
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or above ptr_i,
// wrapping at N.
module rr_pick
  import memfifo_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          hit_o
);

  logic [7:0] oh;
  int         cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    onehot_o = '0;
    idx_o    = '0;
    hit_o    = 1'b0;
    oh       = '0;
    cand     = 0;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N;
      if (req_i[IW'(cand)]) begin
        hit_o    = 1'b1;
        idx_o    = IW'(cand);
        oh       = onehot(3'(cand));
        onehot_o = oh[N-1:0];
      end
    end
  end

endmodule

// File: rtl/memfifo_write_arbiter.sv
// Burst-locked round-robin arbiter in front of the dram_fifo write port.
// Optional per-requester word counters are built when FIFO_ARB_STATS_EN is defined.
module memfifo_write_arbiter
  import memfifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = 32
) (
  input  logic                           ifclk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_REQ*FIFO_WORD_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic [FIFO_WORD_W-1:0]         fifo_data_in,
  output logic                           fifo_wr_en,
  input  logic                           fifo_wr_full,
  input  logic                           fifo_wr_err,
  output logic                           wr_err_sticky,
  output logic                           busy,
  output logic [NUM_REQ*CNT_W-1:0]       stat_words
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [BEAT_W-1:0]      beat_cnt_q;
  logic                   out_valid_q;
  logic [FIFO_WORD_W-1:0] out_data_q;
  logic                   err_q;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_hit;

  logic                   slot_free;
  logic                   accept;
  logic                   burst_end;
  logic [IDX_W-1:0]       next_ptr;
  logic [FIFO_WORD_W-1:0] acc_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .hit_o    (pick_hit)
  );

  // The output register can take a word if empty or if it drains this cycle.
  assign slot_free = ~out_valid_q | ~fifo_wr_full;

  always_comb begin
    req_ready = '0;
    if (state_q == BURST && !flush) req_ready[gidx_q] = slot_free;
  end

  assign accept    = req_valid[gidx_q] & req_ready[gidx_q];
  assign acc_data  = req_data[gidx_q*FIFO_WORD_W +: FIFO_WORD_W];
  assign burst_end = req_last[gidx_q] | (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
  assign next_ptr  = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= ARB;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (fifo_wr_err) err_q <= 1'b1;

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_data;
      end else if (fifo_wr_en) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ARB: begin
          if (pick_hit) begin
            grant_q    <= pick_oh;
            gidx_q     <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (burst_end) begin
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
              state_q  <= ARB;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign fifo_wr_en    = out_valid_q & ~fifo_wr_full;
  assign fifo_data_in  = out_data_q;
  assign grant         = grant_q;
  assign wr_err_sticky = err_q;
  assign busy          = (state_q == BURST) | out_valid_q;

`ifdef FIFO_ARB_STATS_EN
  // Saturating per-requester counters; flush deliberately leaves them alone.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge ifclk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (accept && gidx_q == IDX_W'(i) && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign stat_words[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign stat_words = '0;
`endif

endmodule
